// File: rtl/gaussian_window_ctrl.sv
// gaussian_window_ctrl: turns a raster pixel stream into one 3x3 window per
// pixel for the downstream Gaussian MAC. Two line buffers plus six tap
// registers form the window pipeline. Border taps are masked as the output
// slot is loaded.
// Build option: define GAUSS_REPLICATE_BORDER_EN to clamp out-of-image taps
// to the nearest in-image pixel instead of zero padding.
//
// state   | meaning
// S_IDLE  | waiting for pixel 0 of a frame
// S_FILL  | priming the line buffers, no windows out
// S_RUN   | one window out per accepted pixel (centre lags by IMG_W+1)
// S_DRAIN | input closed, zeros shifted in to flush the last IMG_W+1 windows
module gaussian_window_ctrl #(
   parameter int IMG_W = 512,
   parameter int IMG_H = 512,
   parameter int PIX_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PIX_W-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [9*PIX_W-1:0]       out_win,
   output logic [$clog2(IMG_H)-1:0] out_row,
   output logic [$clog2(IMG_W)-1:0] out_col,
   output logic                     out_last,
   output logic                     frame_done,
   output logic                     busy
);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int COL_W = $clog2(IMG_W);
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(NPIX);
   localparam int DLY   = IMG_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

   state_t                 r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_pix_cnt;
   logic [COL_W-1:0]       r_lb_ptr;
   logic [PIX_W-1:0]       r_lb0 [IMG_W];
   logic [PIX_W-1:0]       r_lb1 [IMG_W];
   logic [PIX_W-1:0]       r_w1, r_w2, r_w4, r_w5, r_w7, r_w8;
   logic [ROW_W-1:0]       r_ctr_row;
   logic [COL_W-1:0]       r_ctr_col;
   logic                   r_out_valid, r_out_last;
   logic [9*PIX_W-1:0]     r_out_win;
   logic [ROW_W-1:0]       r_out_row;
   logic [COL_W-1:0]       r_out_col;

   logic                   w_slot_free, w_accept, w_drain_shift, w_shift, w_load;
   logic                   w_ctr_last, w_frame_done;
   logic                   w_top, w_bot, w_lft, w_rgt;
   logic [PIX_W-1:0]       w_pix, w_lb0_rd, w_lb1_rd;
   logic [PIX_W-1:0]       w_tap [9];
   logic [PIX_W-1:0]       w_msk [9];
   logic [9*PIX_W-1:0]     w_win;

   assign w_slot_free   = !r_out_valid || out_ready;
   assign in_ready      = (r_state != S_DRAIN) && w_slot_free;
   assign w_accept      = in_valid && in_ready;
   // r_out_last blocks further drain shifts once the final centre is loaded
   assign w_drain_shift = (r_state == S_DRAIN) && w_slot_free && !r_out_last;
   assign w_shift       = w_accept || w_drain_shift;
   assign w_load        = ((r_state == S_RUN) && w_accept) || w_drain_shift;
   assign w_frame_done  = r_out_valid && out_ready && r_out_last;
   assign w_pix         = (r_state == S_DRAIN) ? '0 : in_data;
   assign w_lb0_rd      = r_lb0[r_lb_ptr];
   assign w_lb1_rd      = r_lb1[r_lb_ptr];
   assign w_ctr_last    = (r_ctr_row == ROW_W'(IMG_H-1)) && (r_ctr_col == COL_W'(IMG_W-1));
   assign w_top         = (r_ctr_row == '0);
   assign w_bot         = (r_ctr_row == ROW_W'(IMG_H-1));
   assign w_lft         = (r_ctr_col == '0);
   assign w_rgt         = (r_ctr_col == COL_W'(IMG_W-1));

   assign out_valid  = r_out_valid;
   assign out_win    = r_out_win;
   assign out_row    = r_out_row;
   assign out_col    = r_out_col;
   assign out_last   = r_out_last;
   assign frame_done = w_frame_done;
   assign busy       = (r_state != S_IDLE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_FILL;
         S_FILL:  if (w_accept && (r_pix_cnt == CNT_W'(DLY-1))) w_state_nxt = S_RUN;
         S_RUN:   if (w_accept && (r_pix_cnt == CNT_W'(NPIX-1))) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_frame_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // line buffers: lb0 delays by IMG_W, lb1 by 2*IMG_W; contents left unreset
   always_ff @(posedge clk) begin
      if (w_shift) begin
         r_lb0[r_lb_ptr] <= w_pix;
         r_lb1[r_lb_ptr] <= w_lb0_rd;
      end
   end

   // new window taps (tap 8 newest) and border treatment
   always_comb begin
      w_tap[8] = w_pix;
      w_tap[7] = r_w8;
      w_tap[6] = r_w7;
      w_tap[5] = w_lb0_rd;
      w_tap[4] = r_w5;
      w_tap[3] = r_w4;
      w_tap[2] = w_lb1_rd;
      w_tap[1] = r_w2;
      w_tap[0] = r_w1;
      for (int k = 0; k < 9; k++) w_msk[k] = w_tap[k];
`ifdef GAUSS_REPLICATE_BORDER_EN
      // rows clamp first so corners pick up the already-clamped centre row
      if (w_top) for (int c = 0; c < 3; c++) w_msk[c]   = w_msk[c+3];
      if (w_bot) for (int c = 0; c < 3; c++) w_msk[c+6] = w_msk[c+3];
      if (w_lft) for (int r = 0; r < 3; r++) w_msk[3*r]   = w_msk[3*r+1];
      if (w_rgt) for (int r = 0; r < 3; r++) w_msk[3*r+2] = w_msk[3*r+1];
`else
      if (w_top) for (int c = 0; c < 3; c++) w_msk[c]   = '0;
      if (w_bot) for (int c = 0; c < 3; c++) w_msk[c+6] = '0;
      if (w_lft) for (int r = 0; r < 3; r++) w_msk[3*r]   = '0;
      if (w_rgt) for (int r = 0; r < 3; r++) w_msk[3*r+2] = '0;
`endif
      w_win = '0;
      for (int k = 0; k < 9; k++) w_win[PIX_W*k +: PIX_W] = w_msk[k];
   end

   // pipeline taps, counters and output slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_cnt   <= '0;
         r_lb_ptr    <= '0;
         r_w1        <= '0;
         r_w2        <= '0;
         r_w4        <= '0;
         r_w5        <= '0;
         r_w7        <= '0;
         r_w8        <= '0;
         r_ctr_row   <= '0;
         r_ctr_col   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_win   <= '0;
         r_out_row   <= '0;
         r_out_col   <= '0;
      end else begin
         if (w_accept) begin
            if ((r_state == S_RUN) && (r_pix_cnt == CNT_W'(NPIX-1))) r_pix_cnt <= '0;
            else                                                     r_pix_cnt <= r_pix_cnt + CNT_W'(1);
         end
         if (w_shift) begin
            r_lb_ptr <= (r_lb_ptr == COL_W'(IMG_W-1)) ? '0 : r_lb_ptr + COL_W'(1);
            r_w8 <= w_tap[8];
            r_w7 <= w_tap[7];
            r_w5 <= w_tap[5];
            r_w4 <= w_tap[4];
            r_w2 <= w_tap[2];
            r_w1 <= w_tap[1];
         end
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_ctr_last;
            r_out_win   <= w_win;
            r_out_row   <= r_ctr_row;
            r_out_col   <= r_ctr_col;
            if (!w_ctr_last) begin
               if (r_ctr_col == COL_W'(IMG_W-1)) begin
                  r_ctr_col <= '0;
                  r_ctr_row <= r_ctr_row + ROW_W'(1);
               end else begin
                  r_ctr_col <= r_ctr_col + COL_W'(1);
               end
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
         if (w_frame_done) begin
            r_ctr_row <= '0;
            r_ctr_col <= '0;
         end
      end
   end
endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// tb_gaussian_window_ctrl: 4x3 frames of values 1..12 through the window
// sequencer; expected windows come from a coordinate-based reference model.
module tb_gaussian_window_ctrl;
   localparam int W    = 4;
   localparam int H    = 3;
   localparam int PW   = 8;
   localparam int WH   = W * H;
   localparam int D    = W + 1;
   localparam int WINW = 9 * PW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [PW-1:0]   in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [WINW-1:0] out_win;
   logic [1:0]      out_row;
   logic [1:0]      out_col;
   logic            out_last;
   logic            frame_done;
   logic            busy;

   gaussian_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WINW-1:0] win;
      int              row;
      int              col;
      bit              last;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   acc_in_frame = 0;
   int   win_in_frame = 0;
   int   frames_done = 0;
   bit   first_seen = 1'b0;
   bit   frame_closed = 1'b1;

   task automatic chk(input string tag, input logic [WINW-1:0] obs, input logic [WINW-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [WINW-1:0] pk(input int t0, input int t1, input int t2,
                                           input int t3, input int t4, input int t5,
                                           input int t6, input int t7, input int t8);
      return {PW'(t8), PW'(t7), PW'(t6), PW'(t5), PW'(t4), PW'(t3), PW'(t2), PW'(t1), PW'(t0)};
   endfunction

   function automatic logic [WINW-1:0] model_win(input int row, input int col);
      logic [WINW-1:0] v;
      v = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int r;
            int c;
            int k;
            logic [PW-1:0] px;
            r = row + dr;
            c = col + dc;
            k = (dr + 1) * 3 + (dc + 1);
`ifdef GAUSS_REPLICATE_BORDER_EN
            if (r < 0) r = 0;
            if (r > H - 1) r = H - 1;
            if (c < 0) c = 0;
            if (c > W - 1) c = W - 1;
            px = PW'(r * W + c + 1);
`else
            px = (r < 0 || r >= H || c < 0 || c >= W) ? '0 : PW'(r * W + c + 1);
`endif
            v[PW*k +: PW] = px;
         end
      end
      return v;
   endfunction

   task automatic push_centre(input int m);
      exp_t e;
      e.row  = m / W;
      e.col  = m % W;
      e.win  = model_win(e.row, e.col);
      e.last = (m == WH - 1);
      sb.push_back(e);
   endtask

   // scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         acc_in_frame = 0;
         win_in_frame = 0;
         first_seen   = 1'b0;
         frame_closed = 1'b1;
      end else begin
         if (out_valid && !first_seen) begin
            first_seen = 1'b1;
            chk("first_valid_accepts", WINW'(acc_in_frame), WINW'(D + 1));
         end
         if (acc_in_frame == WH && busy) chk("drain_in_ready", WINW'(in_ready), WINW'(0));
         if (out_valid && out_ready) begin
            chk("sb_not_empty", WINW'(sb.size() != 0), WINW'(1));
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk($sformatf("win(%0d,%0d)", e.row, e.col), out_win, e.win);
               chk("row", WINW'(out_row), WINW'(e.row));
               chk("col", WINW'(out_col), WINW'(e.col));
               chk("last", WINW'(out_last), WINW'(e.last));
`ifdef GAUSS_REPLICATE_BORDER_EN
               if (e.row == 0 && e.col == 0) chk("lit_0_0", out_win, pk(1,1,2, 1,1,2, 5,5,6));
               if (e.row == 2 && e.col == 3) chk("lit_2_3", out_win, pk(7,8,8, 11,12,12, 11,12,12));
`else
               if (e.row == 0 && e.col == 0) chk("lit_0_0", out_win, pk(0,0,0, 0,1,2, 0,5,6));
               if (e.row == 2 && e.col == 3) chk("lit_2_3", out_win, pk(7,8,0, 11,12,0, 0,0,0));
`endif
               if (e.row == 1 && e.col == 1) chk("lit_1_1", out_win, pk(1,2,3, 5,6,7, 9,10,11));
            end
            win_in_frame++;
         end
         if (frame_done) begin
            chk("frame_done_on_last", WINW'(out_valid && out_ready && out_last), WINW'(1));
            chk("windows_per_frame", WINW'(win_in_frame), WINW'(WH));
            frames_done++;
            frame_closed = 1'b1;
            win_in_frame = 0;
         end
         if (in_valid && in_ready) begin
            if (acc_in_frame == WH) begin
               chk("next_frame_after_done", WINW'(frame_closed), WINW'(1));
               acc_in_frame = 0;
               first_seen   = 1'b0;
            end
            if (acc_in_frame == 0) frame_closed = 1'b0;
            if (acc_in_frame >= D) push_centre(acc_in_frame - D);
            if (acc_in_frame == WH - 1)
               for (int m = WH - D; m < WH; m++) push_centre(m);
            acc_in_frame++;
         end
      end
   end

   task automatic run_frames(input int nframes, input bit stall_en);
      int g;
      int stall_left;
      int target;
      bit acc;
      bit stalled;
      bit finished;
      g = 0;
      stall_left = 0;
      stalled = 1'b0;
      finished = 1'b0;
      target = frames_done + nframes;
      in_valid = 1'b1;
      in_data = PW'(1);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 500 && !finished; cyc++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) g++;
         if (g >= nframes * WH) in_valid = 1'b0;
         in_data = PW'(g % WH + 1);
         if (stall_left > 0) begin
            chk("stall_valid", WINW'(out_valid), WINW'(1));
            chk("stall_win", out_win, model_win(1, 2));
            chk("stall_row", WINW'(out_row), WINW'(1));
            chk("stall_col", WINW'(out_col), WINW'(2));
            chk("stall_in_ready", WINW'(in_ready), WINW'(0));
            stall_left--;
            if (stall_left == 0) out_ready = 1'b1;
         end else if (stall_en && !stalled && out_valid && out_row == 2'd1 && out_col == 2'd2) begin
            out_ready = 1'b0;
            stall_left = 5;
            stalled = 1'b1;
         end
         if (frames_done >= target) finished = 1'b1;
      end
      chk("frames_complete", WINW'(finished), WINW'(1));
      chk("stall_applied", WINW'(stalled), WINW'(stall_en));
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      int g;
      bit acc;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", WINW'(out_valid), WINW'(0));
      chk("rst_out_last", WINW'(out_last), WINW'(0));
      chk("rst_frame_done", WINW'(frame_done), WINW'(0));
      chk("rst_busy", WINW'(busy), WINW'(0));
      chk("rst_out_win", out_win, '0);
      chk("rst_out_rowcol", WINW'({out_row, out_col}), WINW'(0));
      chk("rst_in_ready", WINW'(in_ready), WINW'(1));
      rst_n = 1'b1;

      run_frames(2, 1'b1);
      chk("frames_after_two", WINW'(frames_done), WINW'(2));
      chk("sb_empty_two", WINW'(sb.size()), WINW'(0));

      g = 0;
      in_valid = 1'b1;
      in_data = PW'(1);
      for (int cyc = 0; cyc < 100 && g < 7; cyc++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) g++;
         in_data = PW'(g + 1);
      end
      chk("pre_rst_accepts", WINW'(g), WINW'(7));
      chk("pre_rst_valid", WINW'(out_valid), WINW'(1));
      chk("pre_rst_busy", WINW'(busy), WINW'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", WINW'(out_valid), WINW'(0));
      chk("mid_rst_busy", WINW'(busy), WINW'(0));
      chk("mid_rst_win", out_win, '0);
      chk("mid_rst_rowcol", WINW'({out_row, out_col}), WINW'(0));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_frames(1, 1'b0);
      chk("frames_after_reset", WINW'(frames_done), WINW'(3));
      chk("sb_empty_end", WINW'(sb.size()), WINW'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
